// File: rtl/handshake_arbiter_pkg.sv
// Shared constants and helpers for the peripheral-bus message collector.
// Synthesizable at elaboration time only; no logic lives here.
package handshake_arbiter_pkg;

    localparam bit TRUE  = 1'b1;
    localparam bit FALSE = 1'b0;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int p = 1; p < v; p = p * 2) r++;
        return r;
    endfunction

endpackage

// File: rtl/handshake_arbiter_sync_fifo.sv
// Single-clock FIFO with occupancy count; storage is intentionally not reset.
// A push while full is only honoured together with a pop in the same cycle.
module sync_fifo
    import handshake_arbiter_pkg::*;
#(
    parameter  int WID   = 10,
    parameter  int DEPTH = 4,
    localparam int AW    = clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic           Clock,
    input  logic           Reset,
    input  logic           push_i,
    input  logic [WID-1:0] din_i,
    input  logic           pop_i,
    output logic [WID-1:0] dout_o,
    output logic           full_o,
    output logic           empty_o,
    output logic [CW-1:0]  count_o
);

    logic [WID-1:0] mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           wr_en, rd_en;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign rd_en = pop_i & ~empty_o;
    assign wr_en = push_i & (~full_o | rd_en);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (wr_en) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/handshake_arbiter.sv
// Multi-channel message collector: per-channel capture, round-robin grant,
// and a shared queue drained by one consumer over a ready/ack handshake.
module handshake_arbiter
    import handshake_arbiter_pkg::*;
#(
    parameter  int WID_DATA = 8,
    parameter  int NUM_CH   = 4,
    parameter  int DEPTH    = 4,
    localparam int WID_CH   = clog2(NUM_CH)
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic [NUM_CH-1:0]          T_Start,
    input  logic [NUM_CH*WID_DATA-1:0] T_Data,
    output logic [NUM_CH-1:0]          T_Busy,
    output logic [NUM_CH-1:0]          T_Dropped,
    output logic [WID_DATA-1:0]        R_Data,
    output logic [WID_CH-1:0]          R_Channel,
    output logic                       R_DataReady,
    input  logic                       R_Ack
);

    localparam int CW = clog2(DEPTH) + 1;
    localparam int EW = WID_CH + WID_DATA;

    logic [NUM_CH-1:0]   busy_q, busy_d;
    logic [NUM_CH-1:0]   drop_q, drop_d;
    logic [WID_CH-1:0]   ptr_q, ptr_d;
    logic [WID_DATA-1:0] hold_q [NUM_CH];

    logic              gnt_vld;
    logic [WID_CH-1:0] gnt_idx;
    logic [WID_CH-1:0] cand;
    logic              push_ok, pop;
    logic              full, empty;
    logic [CW-1:0]     count;
    logic [EW-1:0]     head;

    assign T_Busy      = busy_q;
    assign T_Dropped   = drop_q;
    assign R_DataReady = (count != '0);
    assign pop         = R_Ack & ~empty;
    // A full queue still accepts a grant when the consumer frees a slot now
    assign push_ok     = ~full | pop;

    always_comb begin
        gnt_vld = FALSE;
        gnt_idx = '0;
        cand    = '0;
        if (push_ok) begin
            for (int k = 1; k <= NUM_CH; k++) begin
                cand = WID_CH'((int'(ptr_q) + k) % NUM_CH);
                if (!gnt_vld && busy_q[cand]) begin
                    gnt_vld = TRUE;
                    gnt_idx = cand;
                end
            end
        end
    end

    // A start seen while busy is dropped even if the grant clears busy now
    always_comb begin
        busy_d = busy_q;
        drop_d = drop_q;
        ptr_d  = ptr_q;
        if (gnt_vld) begin
            busy_d[gnt_idx] = FALSE;
            ptr_d           = gnt_idx;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (T_Start[i]) begin
                if (busy_q[i]) drop_d[i] = TRUE;
                else           busy_d[i] = TRUE;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            busy_q <= '0;
            drop_q <= '0;
            ptr_q  <= WID_CH'(NUM_CH - 1);
        end else begin
            busy_q <= busy_d;
            drop_q <= drop_d;
            ptr_q  <= ptr_d;
        end
    end

    always_ff @(posedge Clock) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (T_Start[i] && !busy_q[i])
                hold_q[i] <= T_Data[i*WID_DATA +: WID_DATA];
        end
    end

    sync_fifo #(
        .WID   (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .Clock   (Clock),
        .Reset   (Reset),
        .push_i  (gnt_vld),
        .din_i   ({gnt_idx, hold_q[gnt_idx]}),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    assign R_Channel = head[EW-1:WID_DATA];
    assign R_Data    = head[WID_DATA-1:0];

endmodule

// File: tb/tb_handshake_arbiter.sv
// Scoreboard bench for handshake_arbiter: directed scenarios plus random
// traffic, checked against a queue-based reference model.
module tb_handshake_arbiter;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int D  = 4;
    localparam int WC = 2;

    logic           Clock = 1'b0;
    logic           Reset;
    logic [N-1:0]   T_Start;
    logic [N*W-1:0] T_Data;
    logic [N-1:0]   T_Busy;
    logic [N-1:0]   T_Dropped;
    logic [W-1:0]   R_Data;
    logic [WC-1:0]  R_Channel;
    logic           R_DataReady;
    logic           R_Ack;

    always #5 Clock = ~Clock;

    handshake_arbiter #(
        .WID_DATA (W),
        .NUM_CH   (N),
        .DEPTH    (D)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .T_Start     (T_Start),
        .T_Data      (T_Data),
        .T_Busy      (T_Busy),
        .T_Dropped   (T_Dropped),
        .R_Data      (R_Data),
        .R_Channel   (R_Channel),
        .R_DataReady (R_DataReady),
        .R_Ack       (R_Ack)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Reference model: pending words per channel, a plain queue for the FIFO
    bit   [N-1:0]      mbusy;
    bit   [N-1:0]      mdrop;
    logic [W-1:0]      mhold [N];
    int                mptr;
    logic [WC+W-1:0]   mq[$];
    logic [WC+W-1:0]   exp_q[$];
    logic [WC+W-1:0]   obs[$];
    bit                mon_en = 1'b0;

    bit   [N-1:0] pre;
    int           g;
    bit           mpop;
    int           c;

    always @(posedge Clock) begin
        if (Reset) begin
            mbusy = '0;
            mdrop = '0;
            mptr  = N - 1;
            mq.delete();
            exp_q.delete();
        end else begin
            mpop = R_Ack && (mq.size() > 0);
            pre  = mbusy;
            g    = -1;
            if (mq.size() < D || mpop) begin
                for (int k = 1; k <= N; k++) begin
                    c = (mptr + k) % N;
                    if (g < 0 && mbusy[c]) g = c;
                end
            end
            if (mpop) void'(mq.pop_front());
            if (g >= 0) begin
                mq.push_back({WC'(g), mhold[g]});
                exp_q.push_back({WC'(g), mhold[g]});
                mbusy[g] = 1'b0;
                mptr     = g;
            end
            for (int i = 0; i < N; i++) begin
                if (T_Start[i]) begin
                    if (pre[i]) mdrop[i] = 1'b1;
                    else begin
                        mbusy[i] = 1'b1;
                        mhold[i] = T_Data[i*W +: W];
                    end
                end
            end
        end
    end

    // Handshake monitor: every accepted pop must match the next expected entry
    logic [WC+W-1:0] e;
    always @(posedge Clock) begin
        if (mon_en && !Reset && R_Ack && R_DataReady) begin
            obs.push_back({R_Channel, R_Data});
            if (exp_q.size() == 0) begin
                chk("pop_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("pop_channel", 32'(R_Channel), 32'(e[WC+W-1:W]));
                chk("pop_data", 32'(R_Data), 32'(e[W-1:0]));
            end
        end
    end

    always @(negedge Clock) begin
        if (mon_en) begin
            chk("ready_level", 32'(R_DataReady), 32'(mq.size() != 0));
            chk("busy_flags", 32'(T_Busy), 32'(mbusy));
            chk("dropped_flags", 32'(T_Dropped), 32'(mdrop));
        end
    end

    task automatic step(input logic rst, input logic [N-1:0] s,
                        input logic [N*W-1:0] d, input logic a);
        @(negedge Clock);
        Reset   = rst;
        T_Start = s;
        T_Data  = d;
        R_Ack   = a;
    endtask

    task automatic settle;
        @(posedge Clock);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    int base;
    int starts;
    int bad;
    int n33;
    int n77;
    logic [N-1:0] s;

    initial begin
        Reset   = 1'b1;
        T_Start = '0;
        T_Data  = '0;
        R_Ack   = 1'b0;
        repeat (2) @(posedge Clock);
        #2;
        mon_en = 1'b1;
        chk("reset_busy", 32'(T_Busy), 32'd0);
        chk("reset_dropped", 32'(T_Dropped), 32'd0);
        chk("reset_ready", 32'(R_DataReady), 32'd0);

        // Single message on ch2
        step(0, 4'b0100, 32'h00A5_0000, 0); settle;
        chk("t1_busy_set", 32'(T_Busy[2]), 32'd1);
        chk("t1_ready_early", 32'(R_DataReady), 32'd0);
        step(0, '0, '0, 0); settle;
        chk("t1_busy_clr", 32'(T_Busy[2]), 32'd0);
        chk("t1_ready", 32'(R_DataReady), 32'd1);
        chk("t1_data", 32'(R_Data), 32'hA5);
        chk("t1_chan", 32'(R_Channel), 32'd2);
        step(0, '0, '0, 1); settle;
        chk("t1_ready_after_ack", 32'(R_DataReady), 32'd0);

        // Contention from a freshly reset pointer
        step(1, '0, '0, 0); settle;
        step(0, 4'b1111, 32'h1312_1110, 0); settle;
        for (int j = 1; j <= 4; j++) begin
            step(0, '0, '0, 0); settle;
            chk("t2_busy3", 32'(T_Busy[3]), 32'(j < 4));
        end
        for (int k = 0; k < 4; k++) begin
            chk("t2_order_data", 32'(R_Data), 32'(8'h10 + k));
            chk("t2_order_chan", 32'(R_Channel), 32'(k));
            step(0, '0, '0, 1); settle;
        end
        step(0, '0, '0, 0); settle;
        chk("t2_drained", 32'(R_DataReady), 32'd0);

        // Full queue back-pressure
        for (int k = 0; k < 4; k++) begin
            step(0, 4'b0001, 32'(8'h20 + k), 0); settle;
            step(0, '0, '0, 0); settle;
        end
        step(0, 4'b0001, 32'h24, 0); settle;
        for (int k = 0; k < 3; k++) begin
            step(0, '0, '0, 0); settle;
            chk("t3_busy_held", 32'(T_Busy[0]), 32'd1);
        end
        chk("t3_head", 32'(R_Data), 32'h20);
        step(0, '0, '0, 1); settle;
        chk("t3_busy_pushed", 32'(T_Busy[0]), 32'd0);
        for (int k = 0; k < 4; k++) begin
            chk("t3_drain", 32'(R_Data), 32'(8'h21 + k));
            step(0, '0, '0, 1); settle;
        end
        step(0, '0, '0, 0); settle;
        chk("t3_count4", 32'(R_DataReady), 32'd0);

        // Fairness between two always-hungry channels
        base   = obs.size();
        starts = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge Clock);
            s       = {2'b00, ~T_Busy[1:0]};
            Reset   = 1'b0;
            T_Start = s;
            T_Data  = 32'($urandom);
            R_Ack   = 1'b1;
            starts += int'(s[0]) + int'(s[1]);
        end
        for (int k = 0; k < 6; k++) step(0, '0, '0, 1);
        settle;
        chk("t4_enough", 32'(obs.size() - base >= 20), 32'd1);
        chk("t4_none_lost", 32'(obs.size() - base), 32'(starts));
        bad = 0;
        for (int k = base + 1; k < obs.size(); k++) begin
            if (obs[k][WC+W-1:W] == obs[k-1][WC+W-1:W]) bad++;
            if (obs[k][WC+W-1:W] > 2'd1) bad++;
        end
        chk("t4_alternate", 32'(bad), 32'd0);

        // Drop while busy
        base = obs.size();
        step(0, 4'b0010, 32'h0000_3300, 0); settle;
        chk("t5_busy1", 32'(T_Busy[1]), 32'd1);
        step(0, 4'b0010, 32'h0000_7700, 0); settle;
        chk("t5_dropped1", 32'(T_Dropped[1]), 32'd1);
        for (int k = 0; k < 3; k++) begin
            step(0, '0, '0, 1); settle;
        end
        n33 = 0;
        n77 = 0;
        for (int k = base; k < obs.size(); k++) begin
            if (obs[k] == {2'd1, 8'h33}) n33++;
            if (obs[k][W-1:0] == 8'h77) n77++;
        end
        chk("t5_first_word", 32'(n33), 32'd1);
        chk("t5_no_77", 32'(n77), 32'd0);

        // Reset with queued and held words
        step(0, 4'b1011, 32'h6300_6160, 0); settle;
        for (int k = 0; k < 3; k++) begin
            step(0, '0, '0, 0); settle;
        end
        step(0, 4'b0100, 32'h0062_0000, 0); settle;
        chk("t6_busy2", 32'(T_Busy[2]), 32'd1);
        step(1, '0, '0, 0); settle;
        chk("t6_ready", 32'(R_DataReady), 32'd0);
        chk("t6_busy", 32'(T_Busy), 32'd0);
        chk("t6_dropped", 32'(T_Dropped), 32'd0);
        step(0, 4'b1001, 32'h7300_0070, 0); settle;
        step(0, '0, '0, 0); settle;
        chk("t6_first_chan", 32'(R_Channel), 32'd0);
        chk("t6_first_data", 32'(R_Data), 32'h70);
        step(0, '0, '0, 0); settle;
        step(0, '0, '0, 1); settle;
        chk("t6_second_chan", 32'(R_Channel), 32'd3);
        chk("t6_second_data", 32'(R_Data), 32'h73);
        step(0, '0, '0, 1); settle;

        // Random traffic with occasional reset
        for (int k = 0; k < 600; k++) begin
            @(negedge Clock);
            Reset = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < N; i++)
                T_Start[i] = ($urandom_range(0, 2) == 0);
            T_Data = 32'($urandom);
            R_Ack  = 1'($urandom_range(0, 1));
        end
        for (int k = 0; k < 12; k++) step(0, '0, '0, 1);
        settle;
        chk("rnd_ready_idle", 32'(R_DataReady), 32'd0);
        chk("rnd_busy_idle", 32'(T_Busy), 32'd0);
        chk("rnd_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
